// File: rtl/histogram_pkg.sv
// Shared constants, FSM state type and timing helper for the histogram UART sender.
package histogram_pkg;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Clock cycles per UART bit, truncating integer division.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/histogram_uart_sender_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit; line idles high.
// CLKS_PER_BIT must be at least 2.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0] STOP_IDX = 4'd9;

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;

  // Bit timing, bit index and shift; byte_done is raised for the last stop-bit cycle.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    done_d   = active_q && (idx_q == STOP_IDX) && (cnt_q == CNT_PRE);
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      idx_d    = '0;
      shreg_d  = data;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (idx_q == STOP_IDX) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          idx_d   = idx_q + 4'd1;
          tx_d    = (idx_q < 4'd8) ? shreg_q[0] : 1'b1;
          shreg_d = {1'b0, shreg_q[7:1]};
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign tx        = tx_q;
  assign byte_done = done_q;

endmodule

// File: rtl/histogram_uart_sender.sv
// Holds histogram bins and sends them as one framed UART packet per transmit edge.
module histogram_uart_sender
  import histogram_pkg::*;
#(
  parameter int unsigned BIN_COUNT = 8,
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         histogram_write_enable,
  input  logic [$clog2(BIN_COUNT)-1:0] histogram_write_address,
  input  logic [15:0]                  histogram_data,
  input  logic                         histogram_transmit,
  output logic                         UART_TX,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned AW     = $clog2(BIN_COUNT);
  localparam int unsigned NBYTES = 2 * BIN_COUNT + 2;
  localparam int unsigned CW     = $clog2(NBYTES);
  localparam int unsigned CPB    = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  state_e          state_q, state_d;
  logic [15:0]     bins_q [BIN_COUNT];
  logic [15:0]     bins_d [BIN_COUNT];
  logic            trans_q;
  logic            armed_q, armed_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]      csum_q, csum_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            start_c;
  logic            ser_start_c;
  logic [CW-1:0]   pidx_c;
  logic [15:0]     word_c;
  logic [7:0]      byte_c;
  logic            byte_done;

  // Bin writes land only while no frame is in flight.
  always_comb begin
    bins_d = bins_q;
    if (histogram_write_enable && !busy_q) begin
      bins_d[histogram_write_address] = histogram_data;
    end
  end

  // Byte mux: header, payload low/high bytes per bin, then checksum.
  always_comb begin
    pidx_c = byte_cnt_q - CW'(1);
    word_c = bins_q[AW'(pidx_c >> 1)];
    byte_c = pidx_c[0] ? word_c[15:8] : word_c[7:0];
    if (byte_cnt_q == '0) begin
      byte_c = FRAME_HEADER;
    end else if (byte_cnt_q == LAST_BYTE) begin
      byte_c = csum_q;
    end
  end

  // Next state, byte counter, checksum and registered status outputs.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    csum_d      = csum_q;
    ser_start_c = 1'b0;
    // A transmit level already high out of reset must drop before it can start a frame.
    armed_d     = armed_q | ~histogram_transmit;
    start_c     = histogram_transmit & ~trans_q & armed_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
          csum_d     = '0;
        end
      end
      LOAD: begin
        ser_start_c = 1'b1;
        state_d     = SEND;
        if (byte_cnt_q != '0 && byte_cnt_q != LAST_BYTE) begin
          csum_d = csum_q + byte_c;
        end
      end
      SEND: begin
        if (byte_done) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = FINISH;
          end else begin
            state_d    = LOAD;
            byte_cnt_d = byte_cnt_q + CW'(1);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == SEND);
    done_d = (state_d == FINISH);
  end

  // Control and bin register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      trans_q    <= 1'b0;
      armed_q    <= 1'b0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < int'(BIN_COUNT); i++) begin
        bins_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      trans_q    <= histogram_transmit;
      armed_q    <= armed_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bins_q     <= bins_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (ser_start_c),
    .data     (byte_c),
    .tx       (UART_TX),
    .byte_done(byte_done)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_histogram_uart_sender.sv
// Bench for histogram_uart_sender: per-cycle expected-waveform model plus decoded-frame checks.
module tb_histogram_uart_sender;

  localparam int BINS      = 8;
  localparam int CPB       = 10;
  localparam int NB        = 2 * BINS + 2;
  localparam int FRAME_CYC = NB * (10 * CPB + 1) + 1;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } obs_t;

  localparam obs_t IDLE_OBS = obs_t'(3'b100);

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] data = '0;
  logic        tr = 1'b0;
  logic        UART_TX, busy, done;

  int checks = 0;
  int errors = 0;

  // model state
  logic [15:0] bins_m [BINS];
  bit          armed_m, prev_m;
  obs_t        exp_q [$];
  obs_t        cur;

  // monitor state
  int   cyc = 0, rise_cyc = 0, fall_cyc = 0, done_cyc = 0, done_cnt = 0;
  bit   busy_prev = 0, fall_seen = 0;
  logic [7:0] rx_q [$];
  logic [7:0] ef [NB];

  always #5 clk = ~clk;

  histogram_uart_sender #(
    .BIN_COUNT(BINS),
    .CLK_FREQ (1000),
    .BAUD     (100)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .histogram_write_enable (we),
    .histogram_write_address(addr),
    .histogram_data         (data),
    .histogram_transmit     (tr),
    .UART_TX                (UART_TX),
    .busy                   (busy),
    .done                   (done)
  );

  // Expected line/busy/done waveform of a whole frame from the current model bins.
  function automatic void build_frame();
    logic [7:0] b [NB];
    logic [7:0] sum;
    logic       v;
    sum  = 8'h00;
    b[0] = 8'hA5;
    for (int i = 0; i < BINS; i++) begin
      b[1 + 2 * i] = bins_m[i][7:0];
      b[2 + 2 * i] = bins_m[i][15:8];
      sum = sum + bins_m[i][7:0] + bins_m[i][15:8];
    end
    b[NB - 1] = sum;
    exp_q.push_back(obs_t'(3'b110));
    for (int k = 0; k < NB; k++) begin
      for (int bi = 0; bi < 10; bi++) begin
        if (bi == 0) v = 1'b0;
        else if (bi == 9) v = 1'b1;
        else v = b[k][bi - 1];
        repeat (CPB) exp_q.push_back(obs_t'({v, 2'b10}));
      end
      if (k != NB - 1) exp_q.push_back(obs_t'(3'b110));
    end
    exp_q.push_back(obs_t'(3'b101));
  endfunction

  // Behavioural model: accepts writes and start edges, advances one expected cycle per clock.
  initial begin
    cur = IDLE_OBS;
    armed_m = 0;
    prev_m = 0;
    for (int i = 0; i < BINS; i++) bins_m[i] = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        exp_q.delete();
        cur = IDLE_OBS;
        armed_m = 0;
        prev_m = 0;
        for (int i = 0; i < BINS; i++) bins_m[i] = '0;
      end else begin
        if (!cur.busy && we) bins_m[addr] = data;
        if (!cur.busy && !cur.done && tr && !prev_m && armed_m) build_frame();
        armed_m = armed_m | !tr;
        prev_m = tr;
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_OBS;
      end
    end
  end

  // Per-cycle compare against the model, plus timing bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      checks++;
      if (UART_TX !== cur.tx || busy !== cur.busy || done !== cur.done) begin
        errors++;
        $display("FAIL cycle_model cyc=%0d got tx=%b busy=%b done=%b required tx=%b busy=%b done=%b",
                 cyc, UART_TX, busy, done, cur.tx, cur.busy, cur.done);
      end
      if (busy === 1'b1 && !busy_prev) begin
        rise_cyc = cyc;
        fall_seen = 0;
      end
      if (UART_TX === 1'b0 && busy === 1'b1 && !fall_seen) begin
        fall_cyc = cyc;
        fall_seen = 1;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      busy_prev = (busy === 1'b1);
    end
  end

  // Mid-bit UART decoder; a byte interrupted by reset is discarded.
  initial begin
    logic [7:0] v;
    bit ab;
    forever begin
      @(negedge clk);
      if (reset_n && UART_TX === 1'b0) begin
        v = '0;
        ab = 0;
        for (int t = 1; t <= CPB / 2 + 9 * CPB; t++) begin
          @(negedge clk);
          if (!reset_n) ab = 1;
          if (t > CPB / 2 && t <= CPB / 2 + 8 * CPB && ((t - CPB / 2) % CPB) == 0)
            v[(t - CPB / 2) / CPB - 1] = UART_TX;
        end
        if (!ab) rx_q.push_back(v);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  task automatic write_bin(input int a, input logic [15:0] v);
    @(negedge clk);
    we = 1'b1;
    addr = 3'(a);
    data = v;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic pulse_tx();
    @(negedge clk);
    tr = 1'b1;
    @(negedge clk);
    tr = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout got done=%b required 1", name, done);
    end
    @(negedge clk);
  endtask

  task automatic check_frame(input string name);
    chk({name, "_len"}, rx_q.size(), NB);
    for (int i = 0; i < NB; i++)
      chk($sformatf("%s_byte%0d", name, i), (i < rx_q.size()) ? int'(rx_q[i]) : -1, int'(ef[i]));
  endtask

  initial begin
    int d0;
    #1 reset_n = 1'b0;
    tick(3);
    chk("reset_tx", int'(UART_TX), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    #2 reset_n = 1'b1;
    tick(3);

    // basic frame
    for (int i = 0; i < BINS; i++) write_bin(i, 16'(i + 1));
    rx_q.delete();
    pulse_tx();
    wait_done("basic_done");
    ef = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00,
           8'h05, 8'h00, 8'h06, 8'h00, 8'h07, 8'h00, 8'h08, 8'h00, 8'h24};
    check_frame("basic");
    chk("start_bit_after_busy", fall_cyc - rise_cyc, 1);
    chk("done_after_busy", done_cyc - rise_cyc, 18 * 101);

    // write order: 1..7 then 0
    for (int i = 1; i < BINS; i++) write_bin(i, 16'hFFFF);
    write_bin(0, 16'h1234);
    rx_q.delete();
    pulse_tx();
    wait_done("order_done");
    ef = '{8'hA5, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h38};
    check_frame("order");

    // write during busy is dropped
    rx_q.delete();
    pulse_tx();
    tick(500);
    write_bin(3, 16'hBEEF);
    wait_done("busywr_done");
    check_frame("busywr");
    write_bin(3, 16'hBEEF);
    rx_q.delete();
    pulse_tx();
    wait_done("beef_done");
    chk("beef_len", rx_q.size(), NB);
    if (rx_q.size() == NB) begin
      chk("beef_b3lo", int'(rx_q[7]), 8'hEF);
      chk("beef_b3hi", int'(rx_q[8]), 8'hBE);
      chk("beef_b1lo", int'(rx_q[3]), 8'hFF);
      chk("beef_csum", int'(rx_q[17]), 8'hE7);
    end

    // held level gives one frame; edge during busy is not queued
    @(negedge clk);
    tr = 1'b1;
    d0 = done_cnt;
    tick(3 * FRAME_CYC);
    chk("hold_one_frame", done_cnt - d0, 1);
    tr = 1'b0;
    tick(2);
    pulse_tx();
    d0 = done_cnt;
    tick(300);
    pulse_tx();
    tick(2 * FRAME_CYC);
    chk("edge_in_busy_ignored", done_cnt - d0, 1);

    // reset in the start bit of byte 5
    pulse_tx();
    tick(407);
    chk("pre_reset_tx_low", int'(UART_TX), 0);
    tr = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_tx", int'(UART_TX), 1);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    tick(3);
    #2 reset_n = 1'b1;
    d0 = done_cnt;
    tick(FRAME_CYC + 200);
    chk("no_frame_after_reset", done_cnt - d0, 0);
    chk("idle_after_reset", int'(busy), 0);
    tr = 1'b0;
    rx_q.delete();
    pulse_tx();
    wait_done("zero_done");
    for (int i = 0; i < NB; i++) ef[i] = 8'h00;
    ef[0] = 8'hA5;
    check_frame("zero");

    // write and edge in the same cycle
    rx_q.delete();
    @(negedge clk);
    we = 1'b1;
    addr = 3'd0;
    data = 16'h00AA;
    tr = 1'b1;
    @(negedge clk);
    we = 1'b0;
    tr = 1'b0;
    wait_done("simul_done");
    for (int i = 0; i < NB; i++) ef[i] = 8'h00;
    ef[0] = 8'hA5;
    ef[1] = 8'hAA;
    ef[NB - 1] = 8'hAA;
    check_frame("simul");

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got no finish required finish before limit");
    $fatal(1, "watchdog");
  end

endmodule
